// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: datapath widths, bubble encoding, fetch FSM states.
package riscv_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    // addi x0,x0,0 -- architectural no-op used as the pipeline bubble
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h00000013;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: captures {pc, instruction, valid} on load, keeps its contents on hold,
// and is replaced by a bubble on flush (flush wins over hold, hold wins over load).
module ifid_reg
    import riscv_pkg::*;
#(
    parameter logic [ILEN-1:0] BUBBLE_INSTR = 32'h00000013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            hold,
    input  logic            flush,
    input  logic [XLEN-1:0] pc_in,
    input  logic [ILEN-1:0] instr_in,
    output logic [XLEN-1:0] pc_out,
    output logic [ILEN-1:0] instr_out,
    output logic            valid_out
);

    // Register update: a bubble carries pc=0 and the no-op encoding so decode sees a harmless word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_out    <= '0;
            instr_out <= BUBBLE_INSTR;
            valid_out <= 1'b0;
        end else if (flush) begin
            pc_out    <= '0;
            instr_out <= BUBBLE_INSTR;
            valid_out <= 1'b0;
        end else if (!hold && load) begin
            pc_out    <= pc_in;
            instr_out <= instr_in;
            valid_out <= 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives the instruction memory address, fills IF/ID, and handles
// stall, branch/jump redirect with flush, end-of-image halt and misaligned-target error.
module instruction_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 64'h0,
    parameter int              MEM_BYTES = 200,
    parameter logic [ILEN-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_target_i,
    output logic [XLEN-1:0] Instr_Addr,
    input  logic [ILEN-1:0] Instruction,
    output logic [XLEN-1:0] ifid_pc_o,
    output logic [ILEN-1:0] ifid_instr_o,
    output logic            ifid_valid_o,
    output logic            halted_o,
    output logic            misalign_err_o,
    output logic [31:0]     fetch_count_o
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            ifid_load, ifid_hold, ifid_flush;
    logic            count_inc, set_err;
    logic            in_bounds, target_aligned;

    // The bound check is widened by one bit so a PC near 2^64 cannot wrap into the legal range.
    assign in_bounds      = ({1'b0, pc_q} + 65'd4) <= 65'(MEM_BYTES);
    assign target_aligned = (redirect_target_i[1:0] == 2'b00);
    assign Instr_Addr     = pc_q;
    assign halted_o       = (state_q == HALT);

    // Next-state and control decode; priority is redirect, then stall, then normal fetch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ifid_load  = 1'b0;
        ifid_hold  = 1'b0;
        ifid_flush = 1'b0;
        count_inc  = 1'b0;
        set_err    = 1'b0;
        case (state_q)
            RUN: begin
                if (redirect_i) begin
                    ifid_flush = 1'b1;
                    if (target_aligned) begin
                        pc_d = redirect_target_i;
                    end else begin
                        set_err = 1'b1;
                        state_d = HALT;
                    end
                end else if (stall_i) begin
                    ifid_hold = 1'b1;
                end else if (in_bounds) begin
                    ifid_load = 1'b1;
                    pc_d      = pc_q + 64'd4;
                    count_inc = 1'b1;
                end else begin
                    ifid_flush = 1'b1;
                    state_d    = HALT;
                end
            end
            HALT: begin
                if (redirect_i) begin
                    ifid_flush = 1'b1;
                    if (target_aligned) begin
                        pc_d    = redirect_target_i;
                        state_d = RUN;
                    end else begin
                        set_err = 1'b1;
                    end
                end else if (stall_i) begin
                    ifid_hold = 1'b1;
                end else begin
                    ifid_flush = 1'b1;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State, PC, sticky error flag and accepted-instruction counter (wraps silently).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= RUN;
            pc_q           <= RESET_PC;
            misalign_err_o <= 1'b0;
            fetch_count_o  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (set_err) begin
                misalign_err_o <= 1'b1;
            end
            if (count_inc) begin
                fetch_count_o <= fetch_count_o + 32'd1;
            end
        end
    end

    ifid_reg #(
        .BUBBLE_INSTR(NOP_INSTR)
    ) u_ifid_reg (
        .clk      (clk),
        .reset    (reset),
        .load     (ifid_load),
        .hold     (ifid_hold),
        .flush    (ifid_flush),
        .pc_in    (pc_q),
        .instr_in (Instruction),
        .pc_out   (ifid_pc_o),
        .instr_out(ifid_instr_o),
        .valid_out(ifid_valid_o)
    );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a combinational instruction-memory model
// holding the relevant words of the bubble-sort image.
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic        halt;
        logic        err;
        logic [31:0] count;
        logic [63:0] addr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [63:0] redirect_target_i = '0;
    logic [63:0] Instr_Addr;
    logic [31:0] Instruction;
    logic [63:0] ifid_pc_o;
    logic [31:0] ifid_instr_o;
    logic        ifid_valid_o;
    logic        halted_o;
    logic        misalign_err_o;
    logic [31:0] fetch_count_o;

    logic [31:0] imem [0:63];
    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    // Instruction memory model: word-indexed, zero beyond the modelled range.
    assign Instruction = (Instr_Addr < 64'd256) ? imem[Instr_Addr[7:2]] : 32'h0;

    instruction_fetch_unit dut (
        .clk              (clk),
        .reset            (reset),
        .stall_i          (stall_i),
        .redirect_i       (redirect_i),
        .redirect_target_i(redirect_target_i),
        .Instr_Addr       (Instr_Addr),
        .Instruction      (Instruction),
        .ifid_pc_o        (ifid_pc_o),
        .ifid_instr_o     (ifid_instr_o),
        .ifid_valid_o     (ifid_valid_o),
        .halted_o         (halted_o),
        .misalign_err_o   (misalign_err_o),
        .fetch_count_o    (fetch_count_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        check({tag, ".ifid_pc"},  ifid_pc_o,      e.pc);
        check({tag, ".instr"},    {32'h0, ifid_instr_o}, {32'h0, e.instr});
        check({tag, ".valid"},    {63'h0, ifid_valid_o}, {63'h0, e.valid});
        check({tag, ".halted"},   {63'h0, halted_o},     {63'h0, e.halt});
        check({tag, ".misalign"}, {63'h0, misalign_err_o}, {63'h0, e.err});
        check({tag, ".count"},    {32'h0, fetch_count_o}, {32'h0, e.count});
        check({tag, ".addr"},     Instr_Addr,     e.addr);
    endtask

    // Drive one cycle of stimulus, queue what IF/ID and status must show after the edge, then compare.
    task automatic step(input string tag, input logic st, input logic rd, input logic [63:0] tgt,
                        input logic [63:0] pc, input logic [31:0] instr, input logic vld,
                        input logic hlt, input logic err, input logic [31:0] cnt,
                        input logic [63:0] addr);
        exp_t e;
        stall_i           = st;
        redirect_i        = rd;
        redirect_target_i = tgt;
        e = '{pc: pc, instr: instr, valid: vld, halt: hlt, err: err, count: cnt, addr: addr};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
        end else begin
            e = sb_q.pop_front();
            check_all(tag, e);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t rst_e;
        for (int i = 0; i < 64; i++) imem[i] = 32'hA5000000 | 32'(i);
        imem[0]  = 32'h00700213;
        imem[1]  = 32'h00000393;
        imem[2]  = 32'h00000313;
        imem[22] = 32'h40658633;
        imem[49] = 32'h00008067;

        rst_e = '{pc: 64'h0, instr: NOP, valid: 1'b0, halt: 1'b0, err: 1'b0, count: 32'd0, addr: 64'h0};

        // Reset state
        @(posedge clk);
        #1;
        check_all("reset", rst_e);
        reset = 1'b0;

        // 1: free-running fetch from reset
        step("t1_e1", 0, 0, 64'h0, 64'h0, 32'h00700213, 1, 0, 0, 32'd1, 64'h4);
        step("t1_e2", 0, 0, 64'h0, 64'h4, 32'h00000393, 1, 0, 0, 32'd2, 64'h8);

        // 2: stall holds PC, IF/ID and count
        for (int i = 0; i < 3; i++)
            step("t2_stall", 1, 0, 64'h0, 64'h4, 32'h00000393, 1, 0, 0, 32'd2, 64'h8);
        step("t2_release", 0, 0, 64'h0, 64'h8, 32'h00000313, 1, 0, 0, 32'd3, 64'hC);

        // 3: redirect overrides a simultaneous stall
        step("t3_redir", 1, 1, 64'h58, 64'h0, NOP, 0, 0, 0, 32'd3, 64'h58);
        step("t3_fetch", 0, 0, 64'h0, 64'h58, 32'h40658633, 1, 0, 0, 32'd4, 64'h5C);

        // 4: misaligned target halts with sticky error; legal redirect resumes
        step("t4_misal", 0, 1, 64'h62, 64'h0, NOP, 0, 1, 1, 32'd4, 64'h5C);
        step("t4_halt", 0, 0, 64'h0, 64'h0, NOP, 0, 1, 1, 32'd4, 64'h5C);
        step("t4_hstall", 1, 0, 64'h0, 64'h0, NOP, 0, 1, 1, 32'd4, 64'h5C);
        step("t4_resume", 0, 1, 64'h0, 64'h0, NOP, 0, 0, 1, 32'd4, 64'h0);
        step("t4_fetch", 0, 0, 64'h0, 64'h0, 32'h00700213, 1, 0, 1, 32'd5, 64'h4);

        // 5: last legal word then end-of-image halt
        step("t5_redir", 0, 1, 64'hC4, 64'h0, NOP, 0, 0, 1, 32'd5, 64'hC4);
        step("t5_last", 0, 0, 64'h0, 64'hC4, 32'h00008067, 1, 0, 1, 32'd6, 64'hC8);
        step("t5_end", 0, 0, 64'h0, 64'h0, NOP, 0, 1, 1, 32'd6, 64'hC8);
        step("t5_stay", 0, 0, 64'h0, 64'h0, NOP, 0, 1, 1, 32'd6, 64'hC8);
        step("t5_hmisal", 0, 1, 64'h3, 64'h0, NOP, 0, 1, 1, 32'd6, 64'hC8);
        step("t5_resume", 0, 1, 64'h40, 64'h0, NOP, 0, 0, 1, 32'd6, 64'h40);

        // 6: asynchronous reset during a redirect at pc=0x40
        stall_i           = 1'b0;
        redirect_i        = 1'b1;
        redirect_target_i = 64'h80;
        #2;
        reset = 1'b1;
        #1;
        check_all("t6_async", rst_e);
        redirect_i = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        step("t6_fetch", 0, 0, 64'h0, 64'h0, 32'h00700213, 1, 0, 0, 32'd1, 64'h4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
